fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_if.sv | 49 ++++
 rtl/fetch.sv | 130 +++++++++++++
 tb/tb_fetch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// regname : shared opcode / register encodings used by fetch and its users.
// fetch_if: execute / instruction-memory / decode signals of the fetch stage.
//   slave  modport : the fetch block itself
//   master modport : the environment (execute, instruction memory, decode)
// Signals:
//   e2f_redirect, e2f_target[15:0]  redirect request and target bundle address
//   f2i_req, f2i_addr[15:0]         instruction-memory request strobe / address
//   i2f_valid, i2f_bundle[215:0]    memory response
//   f2dr_instpipe1..3, f2d_destpipe1..3 [3:0]  slot opcode / destination
//   f2d_data[191:0]                 load data for the three slots
//   flush                           one-cycle squash pulse to decode
// -----------------------------------------------------------------------------
package regname;
  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] LOAD = 4'h1;
  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG2 = 4'h2;
  localparam logic [3:0] REG3 = 4'h3;
endpackage

interface fetch_if;
  logic         e2f_redirect;
  logic [15:0]  e2f_target;
  logic         f2i_req;
  logic [15:0]  f2i_addr;
  logic         i2f_valid;
  logic [215:0] i2f_bundle;
  logic [3:0]   f2dr_instpipe1;
  logic [3:0]   f2dr_instpipe2;
  logic [3:0]   f2dr_instpipe3;
  logic [3:0]   f2d_destpipe1;
  logic [3:0]   f2d_destpipe2;
  logic [3:0]   f2d_destpipe3;
  logic [191:0] f2d_data;
  logic         flush;

  modport slave (
    input  e2f_redirect, e2f_target, i2f_valid, i2f_bundle,
    output f2i_req, f2i_addr, f2dr_instpipe1, f2dr_instpipe2, f2dr_instpipe3,
           f2d_destpipe1, f2d_destpipe2, f2d_destpipe3, f2d_data, flush
  );

  modport master (
    output e2f_redirect, e2f_target, i2f_valid, i2f_bundle,
    input  f2i_req, f2i_addr, f2dr_instpipe1, f2dr_instpipe2, f2dr_instpipe3,
           f2d_destpipe1, f2d_destpipe2, f2d_destpipe3, f2d_data, flush
  );
endinterface

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch: instruction-bundle fetch stage.
// Issues one single-cycle request per bundle, waits for the memory response,
// presents the three slots to decode for one cycle, and handles redirects by
// flushing decode and discarding any response still in flight.
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-low
//   bus    fetch_if.slave (request/response/decode/flush signals)
// Parameter:
//   RESET_PC  bundle address loaded at reset
// -----------------------------------------------------------------------------
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic    clock,
  input  logic    reset,
  fetch_if.slave  bus
);
  import regname::*;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic        w_present;
  logic        w_flush_next;

  logic        r_req;
  logic [15:0] r_addr;
  logic        r_flush;
  logic [3:0]  r_inst [3];
  logic [3:0]  r_dest [3];
  logic [63:0] r_data [3];

  // Per-slot unpacking of the response bundle; slot 0 is the first slot.
  logic [3:0]  w_inst [3];
  logic [3:0]  w_dest [3];
  logic [63:0] w_data [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      assign w_inst[gi] = bus.i2f_bundle[215-8*gi -: 4];
      assign w_dest[gi] = bus.i2f_bundle[211-8*gi -: 4];
      // Only load slots carry data; everything else gets zero.
      assign w_data[gi] = (w_inst[gi] == LOAD) ? bus.i2f_bundle[191-64*gi -: 64] : 64'd0;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_present    = 1'b0;
    w_flush_next = 1'b0;

    case (r_state)
      IDLE:    w_state_next = REQ;
      REQ:     w_state_next = WAIT;
      WAIT: begin
        if (bus.i2f_valid) begin
          w_state_next = REQ;
          w_present    = 1'b1;
          w_pc_next    = r_pc + 16'd1;  // natural 16-bit wrap
        end
      end
      DISCARD: begin
        if (bus.i2f_valid) w_state_next = REQ;
      end
      default: w_state_next = IDLE;
    endcase

    // Redirect overrides everything: the bundle (if any) is dropped.
    if (bus.e2f_redirect) begin
      w_present    = 1'b0;
      w_flush_next = 1'b1;
      w_pc_next    = bus.e2f_target;
      case (r_state)
        IDLE:    w_state_next = REQ;
        REQ:     w_state_next = DISCARD;  // request just issued, response pending
        // A response arriving together with the redirect closes the
        // outstanding request, so there is nothing left to discard.
        WAIT:    w_state_next = bus.i2f_valid ? REQ : DISCARD;
        DISCARD: w_state_next = bus.i2f_valid ? REQ : DISCARD;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State and registered outputs. The request strobe is computed from the
  // next state so that it is high exactly during the REQ cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_flush <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_inst[k] <= NOP;
        r_dest[k] <= REG0;
        r_data[k] <= 64'd0;
      end
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_req   <= (w_state_next == REQ);
      r_addr  <= w_pc_next;
      r_flush <= w_flush_next;
      for (int k = 0; k < 3; k++) begin
        r_inst[k] <= w_present ? w_inst[k] : NOP;
        r_dest[k] <= w_present ? w_dest[k] : REG0;
        r_data[k] <= w_present ? w_data[k] : 64'd0;
      end
    end
  end

  assign bus.f2i_req        = r_req;
  assign bus.f2i_addr       = r_addr;
  assign bus.flush          = r_flush;
  assign bus.f2dr_instpipe1 = r_inst[0];
  assign bus.f2dr_instpipe2 = r_inst[1];
  assign bus.f2dr_instpipe3 = r_inst[2];
  assign bus.f2d_destpipe1  = r_dest[0];
  assign bus.f2d_destpipe2  = r_dest[1];
  assign bus.f2d_destpipe3  = r_dest[2];
  assign bus.f2d_data       = {r_data[0], r_data[1], r_data[2]};

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch: directed self-checking bench for fetch.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_fetch;
  import regname::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fetch_if bus();

  fetch #(.RESET_PC(16'h0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCCC;

  // B1: load/reg3, nop/dest 5, load/dest 7
  localparam logic [215:0] B1 = {LOAD, REG3, NOP, 4'h5, LOAD, 4'h7, D1, D2, D3};
  // B2: nop/reg0, load/reg2, nop/dest 9
  localparam logic [215:0] B2 = {NOP, REG0, LOAD, REG2, NOP, 4'h9, D3, D1, D2};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [15:0] addr);
    chk({tag, ".req"},  {191'd0, bus.f2i_req}, {191'd0, req});
    chk({tag, ".addr"}, {176'd0, bus.f2i_addr}, {176'd0, addr});
  endtask

  task automatic chk_quiet(input string tag, input logic flush);
    chk({tag, ".flush"}, {191'd0, bus.flush}, {191'd0, flush});
    chk({tag, ".inst"},
        {180'd0, bus.f2dr_instpipe1, bus.f2dr_instpipe2, bus.f2dr_instpipe3},
        {180'd0, NOP, NOP, NOP});
    chk({tag, ".dest"},
        {180'd0, bus.f2d_destpipe1, bus.f2d_destpipe2, bus.f2d_destpipe3},
        {180'd0, REG0, REG0, REG0});
    chk({tag, ".data"}, bus.f2d_data, 192'd0);
  endtask

  task automatic chk_slots(input string tag, input logic [23:0] insdest, input logic [191:0] data);
    chk({tag, ".flush"}, {191'd0, bus.flush}, 192'd0);
    chk({tag, ".slots"},
        {168'd0, bus.f2dr_instpipe1, bus.f2d_destpipe1, bus.f2dr_instpipe2,
         bus.f2d_destpipe2, bus.f2dr_instpipe3, bus.f2d_destpipe3},
        {168'd0, insdest});
    chk({tag, ".data"}, bus.f2d_data, data);
  endtask

  initial begin
    bus.e2f_redirect = 1'b0;
    bus.e2f_target   = 16'h0000;
    bus.i2f_valid    = 1'b0;
    bus.i2f_bundle   = '0;

    // Reset state
    tick(); tick();
    chk_bus("reset", 1'b0, 16'h0000);
    chk_quiet("reset", 1'b0);

    // Basic fetch, response one cycle after the request
    reset = 1'b1;
    tick();
    chk_bus("b1_req", 1'b1, 16'h0000);
    chk_quiet("b1_req", 1'b0);
    tick();
    chk_bus("b1_wait", 1'b0, 16'h0000);
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B1;
    tick();
    bus.i2f_valid = 1'b0;
    chk_bus("b1_present", 1'b1, 16'h0001);
    chk_slots("b1_present", {LOAD, REG3, NOP, 4'h5, LOAD, 4'h7}, {D1, 64'd0, D3});

    // Five-cycle memory latency: quiet outputs while waiting, one presentation
    tick();
    chk_bus("lat_w0", 1'b0, 16'h0001);
    chk_quiet("lat_w0", 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_bus($sformatf("lat_w%0d", i), 1'b0, 16'h0001);
      chk_quiet($sformatf("lat_w%0d", i), 1'b0);
    end
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B2;
    tick();
    bus.i2f_valid = 1'b0;
    chk_bus("b2_present", 1'b1, 16'h0002);
    chk_slots("b2_present", {NOP, REG0, LOAD, REG2, NOP, 4'h9}, {64'd0, D1, 64'd0});
    tick();
    chk_bus("b2_after", 1'b0, 16'h0002);
    chk_quiet("b2_after", 1'b0);

    // Redirect during WAIT, late response is discarded
    bus.e2f_redirect = 1'b1; bus.e2f_target = 16'h0040;
    tick();
    bus.e2f_redirect = 1'b0;
    chk_bus("rd_flush", 1'b0, 16'h0040);
    chk_quiet("rd_flush", 1'b1);
    tick();
    chk_quiet("rd_discard", 1'b0);
    chk_bus("rd_discard", 1'b0, 16'h0040);
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B1;
    tick();
    bus.i2f_valid = 1'b0;
    chk_bus("rd_req", 1'b1, 16'h0040);
    chk_quiet("rd_stale", 1'b0);

    // Redirect coincident with a response
    tick();
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B1;
    bus.e2f_redirect = 1'b1; bus.e2f_target = 16'h0123;
    tick();
    bus.i2f_valid = 1'b0; bus.e2f_redirect = 1'b0;
    chk_bus("co_req", 1'b1, 16'h0123);
    chk_quiet("co_drop", 1'b1);
    tick();
    chk_bus("co_wait", 1'b0, 16'h0123);
    chk_quiet("co_wait", 1'b0);

    // pc wrap FFFF -> 0000
    bus.e2f_redirect = 1'b1; bus.e2f_target = 16'hFFFF;
    tick();
    bus.e2f_redirect = 1'b0;
    chk_quiet("wr_flush", 1'b1);
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B2;
    tick();
    bus.i2f_valid = 1'b0;
    chk_bus("wr_req", 1'b1, 16'hFFFF);
    tick();
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B2;
    tick();
    bus.i2f_valid = 1'b0;
    chk_bus("wr_next", 1'b1, 16'h0000);
    chk_slots("wr_present", {NOP, REG0, LOAD, REG2, NOP, 4'h9}, {64'd0, D1, 64'd0});

    // Reset in WAIT with response and redirect both high
    tick();
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B1;
    bus.e2f_redirect = 1'b1; bus.e2f_target = 16'h0555;
    reset = 1'b0;
    tick();
    chk_bus("rst_mid", 1'b0, 16'h0000);
    chk_quiet("rst_mid", 1'b0);
    reset = 1'b1; bus.i2f_valid = 1'b0; bus.e2f_redirect = 1'b0;
    tick();
    chk_bus("rst_req", 1'b1, 16'h0000);
    // Response during REQ after reset release is ignored
    bus.i2f_valid = 1'b1; bus.i2f_bundle = B1;
    tick();
    bus.i2f_valid = 1'b0;
    chk_bus("rst_ign", 1'b0, 16'h0000);
    chk_quiet("rst_ign", 1'b0);
    tick();
    chk_quiet("rst_ign2", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
